// File: rtl/s_term_loopback_ctrl_if.sv
// South-edge termination tile signal bundle: fabric wires, mode chain, monitor.
// Driver side is master; the termination tile is slave.
interface s_term_loopback_ctrl_if;
  logic [3:0]  S1END;
  logic [7:0]  S2MID;
  logic [7:0]  S2END;
  logic [15:0] S4END;
  logic [15:0] SS4END;
  logic [3:0]  N1BEG;
  logic [7:0]  N2BEG;
  logic [7:0]  N2BEGb;
  logic [15:0] N4BEG;
  logic [15:0] NN4BEG;
  logic        cfg_shift;
  logic        cfg_din;
  logic        cfg_dout;
  logic        cfg_load;
  logic        mon_clr;
  logic [15:0] mon_count;

  modport master (
    output S1END, S2MID, S2END, S4END, SS4END,
    output cfg_shift, cfg_din, cfg_load, mon_clr,
    input  N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG,
    input  cfg_dout, mon_count
  );

  modport slave (
    input  S1END, S2MID, S2END, S4END, SS4END,
    input  cfg_shift, cfg_din, cfg_load, mon_clr,
    output N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG,
    output cfg_dout, mon_count
  );
endinterface

// File: rtl/s_term_loopback_ctrl.sv
// South termination switch matrix: reversed loopback with per-group mode chain.
// Optional activity monitor on S4END when S_TERM_ACT_MON_EN is defined.
module s_term_loopback_ctrl #(
  parameter int          NoConfigBits   = 10,
  parameter logic [1:0]  CFG_RESET_MODE = 2'b00
) (
  input  logic                   UserCLK,
  input  logic                   resetn,
  s_term_loopback_ctrl_if.slave  bus
);

  logic [NoConfigBits-1:0] chain_q;
  logic [NoConfigBits-1:0] active_mode;

  logic [3:0]  m1,  p1;
  logic [7:0]  m2,  p2;
  logic [7:0]  m2b, p2b;
  logic [15:0] m4,  p4;
  logic [15:0] mn4, pn4;

  always_comb begin
    m1  = '0;
    m2  = '0;
    m2b = '0;
    m4  = '0;
    mn4 = '0;
    for (int i = 0; i < 4; i++)
      m1[i] = bus.S1END[3-i];
    for (int i = 0; i < 8; i++) begin
      m2[i]  = bus.S2MID[7-i];
      m2b[i] = bus.S2END[7-i];
    end
    for (int i = 0; i < 16; i++) begin
      m4[i]  = bus.S4END[15-i];
      mn4[i] = bus.SS4END[15-i];
    end
  end

  // load reads the pre-shift chain when both strobes coincide
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      chain_q     <= '0;
      active_mode <= {5{CFG_RESET_MODE}};
    end else begin
      if (bus.cfg_load)
        active_mode <= chain_q;
      if (bus.cfg_shift)
        chain_q <= {chain_q[NoConfigBits-2:0], bus.cfg_din};
    end
  end

  assign bus.cfg_dout = chain_q[NoConfigBits-1];

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      p1  <= '0;
      p2  <= '0;
      p2b <= '0;
      p4  <= '0;
      pn4 <= '0;
    end else begin
      p1  <= m1;
      p2  <= m2;
      p2b <= m2b;
      p4  <= m4;
      pn4 <= mn4;
    end
  end

  always_comb begin
    bus.N1BEG = m1;
    unique case (active_mode[1:0])
      2'b00: bus.N1BEG = m1;
      2'b01: bus.N1BEG = p1;
      2'b10: bus.N1BEG = '0;
      2'b11: bus.N1BEG = '1;
    endcase
    bus.N2BEG = m2;
    unique case (active_mode[3:2])
      2'b00: bus.N2BEG = m2;
      2'b01: bus.N2BEG = p2;
      2'b10: bus.N2BEG = '0;
      2'b11: bus.N2BEG = '1;
    endcase
    bus.N2BEGb = m2b;
    unique case (active_mode[5:4])
      2'b00: bus.N2BEGb = m2b;
      2'b01: bus.N2BEGb = p2b;
      2'b10: bus.N2BEGb = '0;
      2'b11: bus.N2BEGb = '1;
    endcase
    bus.N4BEG = m4;
    unique case (active_mode[7:6])
      2'b00: bus.N4BEG = m4;
      2'b01: bus.N4BEG = p4;
      2'b10: bus.N4BEG = '0;
      2'b11: bus.N4BEG = '1;
    endcase
    bus.NN4BEG = mn4;
    unique case (active_mode[9:8])
      2'b00: bus.NN4BEG = mn4;
      2'b01: bus.NN4BEG = pn4;
      2'b10: bus.NN4BEG = '0;
      2'b11: bus.NN4BEG = '1;
    endcase
  end

`ifdef S_TERM_ACT_MON_EN
  logic [15:0] mon_q;

  // new sample differing from the held one means the registered S4END changes
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn)
      mon_q <= '0;
    else if (bus.mon_clr)
      mon_q <= '0;
    else if (m4 != p4 && mon_q != 16'hFFFF)
      mon_q <= mon_q + 16'd1;
  end

  assign bus.mon_count = mon_q;
`else
  logic unused_mon_clr;
  assign unused_mon_clr = bus.mon_clr;
  assign bus.mon_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_s_term_loopback_ctrl.sv
// Directed bench for s_term_loopback_ctrl with a per-cycle behavioural model.
// Monitor checks are active when S_TERM_ACT_MON_EN is defined.
module tb_s_term_loopback_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  s_term_loopback_ctrl_if bus();

  s_term_loopback_ctrl dut (
    .UserCLK (clk),
    .resetn  (resetn),
    .bus     (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [9:0]  m_chain = '0;
  logic [9:0]  m_mode  = '0;
  logic [15:0] m_prev [5];
  logic [15:0] m_mon   = '0;
  int          wid [5] = '{4, 8, 8, 16, 16};

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ins(input int g);
    case (g)
      0: return {12'b0, bus.S1END};
      1: return {8'b0, bus.S2MID};
      2: return {8'b0, bus.S2END};
      3: return bus.S4END;
      default: return bus.SS4END;
    endcase
  endfunction

  function automatic logic [15:0] outs(input int g);
    case (g)
      0: return {12'b0, bus.N1BEG};
      1: return {8'b0, bus.N2BEG};
      2: return {8'b0, bus.N2BEGb};
      3: return bus.N4BEG;
      default: return bus.NN4BEG;
    endcase
  endfunction

  function automatic logic [15:0] rev(input logic [15:0] x, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = x[w-1-i];
    return r;
  endfunction

  function automatic logic [15:0] expect_out(input int g);
    int md;
    md = int'((m_mode >> (2*g)) & 10'd3);
    case (md)
      0: return rev(ins(g), wid[g]);
      1: return rev(m_prev[g], wid[g]);
      2: return 16'h0000;
      default: return 16'hFFFF >> (16 - wid[g]);
    endcase
  endfunction

  task automatic model_reset();
    m_chain = '0;
    m_mode  = '0;
    m_mon   = '0;
    for (int g = 0; g < 5; g++) m_prev[g] = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (resetn) begin
      if (bus.mon_clr) m_mon = '0;
      else if (bus.S4END != m_prev[3] && m_mon != 16'hFFFF) m_mon = m_mon + 1;
      if (bus.cfg_load) m_mode = m_chain;
      if (bus.cfg_shift) m_chain = {m_chain[8:0], bus.cfg_din};
      for (int g = 0; g < 5; g++) m_prev[g] = ins(g);
    end
    #1;
  endtask

  task automatic shift_in(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) begin
      bus.cfg_din   = v[i];
      bus.cfg_shift = 1'b1;
      cycle();
    end
    bus.cfg_shift = 1'b0;
    bus.cfg_din   = 1'b0;
  endtask

  task automatic load();
    bus.cfg_load = 1'b1;
    cycle();
    bus.cfg_load = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 5; g++)
      chk($sformatf("grp%0d", g), outs(g), expect_out(g));
    chk("cfg_dout", {15'b0, bus.cfg_dout}, {15'b0, m_chain[9]});
`ifdef S_TERM_ACT_MON_EN
    chk("mon_count", bus.mon_count, m_mon);
`else
    chk("mon_count", bus.mon_count, 16'h0000);
`endif
  end

  initial begin
    model_reset();
    bus.S1END = '0; bus.S2MID = '0; bus.S2END = '0;
    bus.S4END = '0; bus.SS4END = '0;
    bus.cfg_shift = 0; bus.cfg_din = 0; bus.cfg_load = 0; bus.mon_clr = 0;
    #12 resetn = 1'b1;
    cycle();

    bus.S4END = 16'h0001;
    bus.S1END = 4'b0011;
    #1;
    chk("rst_n4", bus.N4BEG, 16'h8000);
    chk("rst_n1", {12'b0, bus.N1BEG}, 16'h000C);
    chk("rst_dout", {15'b0, bus.cfg_dout}, 16'h0000);
    chk("rst_mon", bus.mon_count, 16'h0000);

    shift_in(10'b0000000001);
    load();
    bus.S1END = 4'h1;
    cycle();
    bus.S1END = 4'h2;
    bus.S2MID = 8'h01;
    #1;
    chk("reg_n1_k", {12'b0, bus.N1BEG}, 16'h0008);
    chk("comb_n2", {8'b0, bus.N2BEG}, 16'h0080);
    cycle();
    chk("reg_n1_k1", {12'b0, bus.N1BEG}, 16'h0004);

    shift_in(10'b1110000000);
    load();
    bus.S4END = 16'hFFFF; bus.SS4END = 16'h0000;
    #1;
    chk("tie_hi_a", bus.NN4BEG, 16'hFFFF);
    chk("tie_lo_a", bus.N4BEG, 16'h0000);
    bus.S4END = 16'h1234; bus.SS4END = 16'h5A5A;
    cycle();
    chk("tie_hi_b", bus.NN4BEG, 16'hFFFF);
    chk("tie_lo_b", bus.N4BEG, 16'h0000);

    shift_in(10'h155);
    bus.S4END = 16'h00F0;
    bus.cfg_shift = 1'b1; bus.cfg_load = 1'b1; bus.cfg_din = 1'b0;
    cycle();
    bus.cfg_shift = 1'b0; bus.cfg_load = 1'b0;
    bus.S4END = 16'h0001;
    #1;
    chk("both_dout", {15'b0, bus.cfg_dout}, 16'h0001);
    chk("both_n4_reg", bus.N4BEG, 16'h0F00);
    cycle();
    chk("both_n4_next", bus.N4BEG, 16'h8000);

    bus.cfg_din = 1'b1; bus.cfg_shift = 1'b1;
    repeat (5) cycle();
    #2 resetn = 1'b0;
    model_reset();
    bus.cfg_shift = 1'b0;
    bus.S2MID = 8'h0F;
    #1;
    chk("mid_rst_n2", {8'b0, bus.N2BEG}, 16'h00F0);
    chk("mid_rst_dout", {15'b0, bus.cfg_dout}, 16'h0000);
    #4 resetn = 1'b1;
    cycle();
    bus.S4END = 16'h0003;
    #1;
    chk("post_rst_n4", bus.N4BEG, 16'hC000);
    repeat (10) cycle();
    chk("post_rst_dout", {15'b0, bus.cfg_dout}, 16'h0000);

`ifdef S_TERM_ACT_MON_EN
    for (int i = 0; i < 70000; i++) begin
      bus.S4END = ~bus.S4END;
      cycle();
    end
    chk("mon_sat", bus.mon_count, 16'hFFFF);
    bus.mon_clr = 1'b1;
    bus.S4END = ~bus.S4END;
    cycle();
    bus.mon_clr = 1'b0;
    chk("mon_clr", bus.mon_count, 16'h0000);
`else
    for (int i = 0; i < 20; i++) begin
      bus.S4END = ~bus.S4END;
      bus.mon_clr = i[0];
      cycle();
    end
    bus.mon_clr = 1'b0;
    chk("mon_off", bus.mon_count, 16'h0000);
`endif

    cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
